// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with a single registered output stage.
// Channel choice is either an explicit select or round-robin starting at ptr.
module stream_mux #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 8,
  parameter int MODE       = 0,
  localparam int SEL_W     = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  input  logic [SEL_W-1:0]            sel,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_src,
  input  logic                        out_ready
);

  // Handshake: a word moves on any port only when valid && ready at posedge clk.
  // The output register accepts a new word whenever it is empty or being drained.
  logic                  load;
  logic [NUM_INPUTS-1:0] grant;
  logic                  any_grant;
  logic [SEL_W-1:0]      grant_idx;
  logic [WIDTH-1:0]      grant_data;
  logic [SEL_W-1:0]      ptr;

  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !rst) ? grant : '0;

  always_comb begin
    grant      = '0;
    any_grant  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant[i]   = 1'b1;
          any_grant  = 1'b1;
          grant_idx  = SEL_W'(i);
          grant_data = in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      // First pass covers ptr..N-1; if nothing is found there, the lowest
      // valid channel below ptr is the next one in wrapped order.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (!any_grant && in_valid[i] && i >= int'(ptr)) begin
          grant[i]   = 1'b1;
          any_grant  = 1'b1;
          grant_idx  = SEL_W'(i);
          grant_data = in_data[i*WIDTH +: WIDTH];
        end
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (!any_grant && in_valid[i]) begin
          grant[i]   = 1'b1;
          any_grant  = 1'b1;
          grant_idx  = SEL_W'(i);
          grant_data = in_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= any_grant;
      if (any_grant) begin
        out_data <= grant_data;
        out_src  <= grant_idx;
        if (MODE != 0) begin
          ptr <= (int'(grant_idx) == NUM_INPUTS - 1) ? '0 : grant_idx + SEL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: four instances (select / round-robin, 4 and 3 channels)
// checked every cycle against a queue-free behavioural model plus directed vectors.
module tb_stream_mux;

  localparam int NI [4] = '{4, 4, 3, 3};
  localparam int MD [4] = '{0, 1, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [3:0]  iv    [4];
  logic [31:0] idata [4];
  logic [1:0]  isel  [4];
  logic        ordy  [4];

  wire  [3:0]  irdy [4];
  wire         ov   [4];
  wire  [7:0]  od   [4];
  wire  [1:0]  os   [4];
  wire  [2:0]  rdy2;
  wire  [2:0]  rdy3;

  assign irdy[2] = {1'b0, rdy2};
  assign irdy[3] = {1'b0, rdy3};

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state per instance
  int mv [4];
  int md [4];
  int ms [4];
  int mp [4];

  stream_mux #(.NUM_INPUTS(4), .WIDTH(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idata[0]), .in_ready(irdy[0]),
    .sel(isel[0]), .out_valid(ov[0]), .out_data(od[0]), .out_src(os[0]), .out_ready(ordy[0]));
  stream_mux #(.NUM_INPUTS(4), .WIDTH(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idata[1]), .in_ready(irdy[1]),
    .sel(isel[1]), .out_valid(ov[1]), .out_data(od[1]), .out_src(os[1]), .out_ready(ordy[1]));
  stream_mux #(.NUM_INPUTS(3), .WIDTH(8), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2][2:0]), .in_data(idata[2][23:0]), .in_ready(rdy2),
    .sel(isel[2]), .out_valid(ov[2]), .out_data(od[2]), .out_src(os[2]), .out_ready(ordy[2]));
  stream_mux #(.NUM_INPUTS(3), .WIDTH(8), .MODE(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3][2:0]), .in_data(idata[3][23:0]), .in_ready(rdy3),
    .sel(isel[3]), .out_valid(ov[3]), .out_data(od[3]), .out_src(os[3]), .out_ready(ordy[3]));

  // clock / reset
  initial begin
    while (!done) #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel the spec's rules pick for instance k, or -1 for none.
  function automatic int grant_of(input int k);
    int n;
    n = NI[k];
    if (MD[k] == 0) begin
      if (int'(isel[k]) < n && iv[k][isel[k]]) return int'(isel[k]);
      return -1;
    end
    for (int j = 0; j < n; j++) begin
      int c;
      c = (mp[k] + j) % n;
      if (iv[k][c]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int k);
    int g;
    if (rst) return 0;
    if (mv[k] != 0 && !ordy[k]) return 0;
    g = grant_of(k);
    return (g >= 0) ? (1 << g) : 0;
  endfunction

  task automatic model_step(input int k);
    int g;
    if (rst) begin
      mv[k] = 0; md[k] = 0; ms[k] = 0; mp[k] = 0;
    end else if (mv[k] == 0 || ordy[k]) begin
      g = grant_of(k);
      if (g >= 0) begin
        mv[k] = 1;
        md[k] = int'((idata[k] >> (8 * g)) & 32'hFF);
        ms[k] = g;
        if (MD[k] != 0) mp[k] = (g + 1) % NI[k];
      end else begin
        mv[k] = 0;
      end
    end
  endtask

  // scoreboard: model advances on each edge, every output compared 1 time unit later
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) model_step(k);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model out_valid[%0d]", k), 64'(ov[k]), 64'(mv[k]));
      if (mv[k] != 0 || rst) begin
        check($sformatf("model out_data[%0d]", k), 64'(od[k]), 64'(md[k]));
        check($sformatf("model out_src[%0d]", k), 64'(os[k]), 64'(ms[k]));
      end
      check($sformatf("model in_ready[%0d]", k), 64'(irdy[k]), 64'(exp_ready(k)));
    end
  end

  // driver: inputs change on the falling edge only; other instances go idle
  task automatic apply(input int k, input logic [3:0] v, input logic [1:0] s,
                       input logic r, input logic [31:0] d);
    @(negedge clk);
    for (int j = 0; j < 4; j++) if (j != k) iv[j] <= '0;
    iv[k]    <= v;
    isel[k]  <= s;
    ordy[k]  <= r;
    idata[k] <= d;
    #1;
  endtask

  task automatic expect_out(input string name, input int k, input logic v,
                            input logic [7:0] d, input logic [1:0] s);
    @(posedge clk);
    #2;
    check({name, " out_valid"}, 64'(ov[k]), 64'(v));
    check({name, " out_data"}, 64'(od[k]), 64'(d));
    check({name, " out_src"}, 64'(os[k]), 64'(s));
  endtask

  typedef struct {
    int         inst;
    logic [3:0] valid;
    logic [1:0] sel;
    logic       ordy;
    logic [31:0] data;
    logic [3:0] erdy;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = '0; idata[k] = '0; isel[k] = '0; ordy[k] = 1'b0;
    end

    // explicit select, channels 0..3, then a missing valid on the selected channel
    vecs.push_back('{0, 4'b1111, 2'd0, 1'b1, 32'h13121110, 4'b0001, 1'b1, 8'h10, 2'd0});
    vecs.push_back('{0, 4'b1111, 2'd1, 1'b1, 32'h13121110, 4'b0010, 1'b1, 8'h11, 2'd1});
    vecs.push_back('{0, 4'b1111, 2'd2, 1'b1, 32'h13121110, 4'b0100, 1'b1, 8'h12, 2'd2});
    vecs.push_back('{0, 4'b1111, 2'd3, 1'b1, 32'h13121110, 4'b1000, 1'b1, 8'h13, 2'd3});
    vecs.push_back('{0, 4'b1011, 2'd2, 1'b1, 32'h13121110, 4'b0000, 1'b0, 8'h13, 2'd3});
    vecs.push_back('{0, 4'b1111, 2'd2, 1'b1, 32'h13A51110, 4'b0100, 1'b1, 8'hA5, 2'd2});
    // three channels: sel beyond the last channel grants nothing
    vecs.push_back('{2, 4'b0111, 2'd3, 1'b1, 32'h00332211, 4'b0000, 1'b0, 8'h00, 2'd0});
    vecs.push_back('{2, 4'b0111, 2'd2, 1'b1, 32'h00332211, 4'b0100, 1'b1, 8'h33, 2'd2});
    // round-robin, all valid for 8 cycles, then channels 1 and 3 only
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1, 4'b1111, 2'd0, 1'b1, 32'h13121110, 4'(1 << (i % 4)),
                       1'b1, 8'(8'h10 + i % 4), 2'(i % 4)});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1, 4'b1010, 2'd0, 1'b1, 32'h13121110, (i % 2 == 0) ? 4'b0010 : 4'b1000,
                       1'b1, (i % 2 == 0) ? 8'h11 : 8'h13, (i % 2 == 0) ? 2'd1 : 2'd3});
    // round-robin over three channels wraps from 2 back to 0
    for (int i = 0; i < 4; i++)
      vecs.push_back('{3, 4'b0111, 2'd0, 1'b1, 32'h00222120, 4'(1 << (i % 3)),
                       1'b1, 8'(8'h20 + i % 3), 2'(i % 3)});

    repeat (3) @(negedge clk);
    rst <= 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].inst, vecs[i].valid, vecs[i].sel, vecs[i].ordy, vecs[i].data);
      check($sformatf("vec%0d in_ready", i), 64'(irdy[vecs[i].inst]), 64'(vecs[i].erdy));
      expect_out($sformatf("vec%0d", i), vecs[i].inst, vecs[i].ev, vecs[i].ed, vecs[i].es);
    end

    // stall: 3C held for three cycles, then released straight into the next grant
    apply(1, 4'b0100, 2'd0, 1'b1, 32'h003C0000);
    expect_out("stall load", 1, 1'b1, 8'h3C, 2'd2);
    for (int i = 0; i < 3; i++) begin
      apply(1, 4'b1111, 2'd0, 1'b0, 32'hD33CD1D0);
      check($sformatf("stall%0d in_ready", i), 64'(irdy[1]), 64'(0));
      expect_out($sformatf("stall%0d", i), 1, 1'b1, 8'h3C, 2'd2);
    end
    apply(1, 4'b1111, 2'd0, 1'b1, 32'hD33CD1D0);
    check("release in_ready", 64'(irdy[1]), 64'(4'b1000));
    expect_out("release", 1, 1'b1, 8'hD3, 2'd3);

    // reset mid-stream with ptr=2 and a held word
    apply(1, 4'b0010, 2'd0, 1'b1, 32'h00004400);
    expect_out("pre-reset", 1, 1'b1, 8'h44, 2'd1);
    @(negedge clk);
    rst <= 1'b1;
    iv[1] <= 4'b1111; ordy[1] <= 1'b0; idata[1] <= 32'h13121110;
    #1;
    check("reset in_ready", 64'(irdy[1]), 64'(0));
    expect_out("reset", 1, 1'b0, 8'h00, 2'd0);
    apply(1, 4'b1111, 2'd0, 1'b1, 32'h13121110);
    rst <= 1'b0;
    #1;
    check("post-reset in_ready", 64'(irdy[1]), 64'(4'b0001));
    expect_out("post-reset", 1, 1'b1, 8'h10, 2'd0);

    // random traffic on all instances, scoreboard checks every cycle
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst <= ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 4; k++) begin
        iv[k]    <= 4'($urandom_range(0, 15)) & ((NI[k] == 3) ? 4'b0111 : 4'b1111);
        idata[k] <= $urandom;
        isel[k]  <= 2'($urandom_range(0, 3));
        ordy[k]  <= ($urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    rst <= 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    done = 1'b1;
    $finish;
  end

endmodule
